// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit and the function decoder, plus the
// helpers that turn an access size and byte offset into bus lane controls.
package lsu_pkg;

  typedef enum logic [1:0] {
    BA_WORD = 2'b00,
    BA_BYTE = 2'b01,
    BA_HALF = 2'b10
  } byte_access_t;

  typedef enum logic [2:0] {
    BS_BU = 3'b000,
    BS_HU = 3'b001,
    BS_B  = 3'b010,
    BS_H  = 3'b011,
    BS_W  = 3'b100
  } byte_src_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Size code 11 falls into the word branch everywhere below.
  function automatic logic [3:0] byteEnable(input logic [1:0] access, input logic [1:0] offset);
    case (access)
      BA_BYTE: byteEnable = 4'b0001 << offset;
      BA_HALF: byteEnable = 4'b0011 << {offset[1], 1'b0};
      default: byteEnable = 4'b1111;
    endcase
  endfunction

  function automatic logic isMisaligned(input logic [1:0] access, input logic [1:0] offset);
    case (access)
      BA_BYTE: isMisaligned = 1'b0;
      BA_HALF: isMisaligned = offset[0];
      default: isMisaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] replicateData(input logic [1:0] access, input logic [31:0] wdata);
    case (access)
      BA_BYTE: replicateData = {4{wdata[7:0]}};
      BA_HALF: replicateData = {2{wdata[15:0]}};
      default: replicateData = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte or halfword out of a read word and extends it
// according to the load format.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  byte_src_i,
  output logic [31:0] result_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = rdata_i[7:0];
    case (addr_i)
      2'b01:   byteLane = rdata_i[15:8];
      2'b10:   byteLane = rdata_i[23:16];
      2'b11:   byteLane = rdata_i[31:24];
      default: byteLane = rdata_i[7:0];
    endcase
    halfLane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    result_o = rdata_i;
    case (byte_src_i)
      BS_BU:   result_o = {24'b0, byteLane};
      BS_HU:   result_o = {16'b0, halfLane};
      BS_B:    result_o = {{24{byteLane[7]}}, byteLane};
      BS_H:    result_o = {{16{halfLane[15]}}, halfLane};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: captures one access, drives a registered bus
// request until acknowledged, and holds the pipeline until the access is done.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        byte_access_i,
  input  logic [2:0]        byte_src_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] result_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        byteSrc_q, byteSrc_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] busWdata_q, busWdata_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] alignedData;

  load_align u_load_align (
    .rdata_i    (bus_rdata_i),
    .addr_i     (addr_q[1:0]),
    .byte_src_i (byteSrc_q),
    .result_o   (alignedData)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      byteSrc_q  <= '0;
      be_q       <= '0;
      busWdata_q <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      byteSrc_q  <= byteSrc_d;
      be_q       <= be_d;
      busWdata_q <= busWdata_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  // Lane enables and replicated store data are computed once at capture so the
  // bus sees only flop outputs for the whole request.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    byteSrc_d  = byteSrc_q;
    be_d       = be_q;
    busWdata_d = busWdata_q;
    result_d   = result_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_i) begin
          addr_d     = addr_i;
          we_d       = mem_write_i;
          byteSrc_d  = byte_src_i;
          be_d       = byteEnable(byte_access_i, addr_i[1:0]);
          busWdata_d = replicateData(byte_access_i, wdata_i);
          result_d   = '0;
          misalign_d = isMisaligned(byte_access_i, addr_i[1:0]);
          state_d    = misalign_d ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_ack_i) begin
          result_d = we_q ? '0 : alignedData;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_o     = mem_valid_i && (state_q != DONE);
  assign done_o      = (state_q == DONE);
  assign misalign_o  = (state_q == DONE) && misalign_q;
  assign result_o    = result_q;
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = (state_q == REQ) && we_q;
  assign bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_be_o    = be_q;
  assign bus_wdata_o = busWdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, a delayed
// acknowledge, a spurious acknowledge and a reset in the middle of a request.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        memValid = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  byteAccess = '0;
  logic [2:0]  byteSrc = '0;
  logic        stall;
  logic [31:0] result;
  logic        done;
  logic        misalign;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic [31:0] busRdata = '0;
  logic        busAck = 1'b0;

  int compareCount = 0;
  int failCount = 0;
  int stallCycles = 0;
  int reqCycles = 0;
  int doneCycles = 0;
  int startStall, startReq, startDone;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .reset_n       (resetN),
    .mem_valid_i   (memValid),
    .mem_write_i   (memWrite),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .byte_access_i (byteAccess),
    .byte_src_i    (byteSrc),
    .stall_o       (stall),
    .result_o      (result),
    .done_o        (done),
    .misalign_o    (misalign),
    .bus_req_o     (busReq),
    .bus_we_o      (busWe),
    .bus_addr_o    (busAddr),
    .bus_be_o      (busBe),
    .bus_wdata_o   (busWdata),
    .bus_rdata_i   (busRdata),
    .bus_ack_i     (busAck)
  );

  always #5 clk = ~clk;

  // Cycle counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (stall)  stallCycles++;
    if (busReq) reqCycles++;
    if (done)   doneCycles++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] acc, input logic [2:0] src);
    memValid   = valid;
    memWrite   = write;
    addr       = a;
    wdata      = d;
    byteAccess = acc;
    byteSrc    = src;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot;
    startStall = stallCycles;
    startReq   = reqCycles;
    startDone  = doneCycles;
  endtask

  initial begin
    $display("[TB] start");
    #1 resetN = 1'b0;
    @(negedge clk);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("rst_req", {31'b0, busReq}, 32'd0);
    checkOutput("rst_we", {31'b0, busWe}, 32'd0);
    checkOutput("rst_addr", busAddr, 32'd0);
    checkOutput("rst_be", {28'b0, busBe}, 32'd0);
    checkOutput("rst_wdata", busWdata, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    tick;
    resetN = 1'b1;
    tick;

    // Load byte signed at 0x103.
    snapshot;
    applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 2'b01, 3'b010);
    @(negedge clk);
    checkOutput("lb_idle_stall", {31'b0, stall}, 32'd1);
    checkOutput("lb_idle_req", {31'b0, busReq}, 32'd0);
    tick;
    busAck = 1'b1;
    busRdata = 32'h80FF7F01;
    @(negedge clk);
    checkOutput("lb_req", {31'b0, busReq}, 32'd1);
    checkOutput("lb_we", {31'b0, busWe}, 32'd0);
    checkOutput("lb_addr", busAddr, 32'h100);
    checkOutput("lb_be", {28'b0, busBe}, 32'h8);
    tick;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("lb_done", {31'b0, done}, 32'd1);
    checkOutput("lb_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("lb_result", result, 32'hFFFFFF80);
    checkOutput("lb_done_stall", {31'b0, stall}, 32'd0);
    tick;
    checkOutput("lb_stall_cycles", stallCycles - startStall, 32'd2);

    // Back-to-back: load half unsigned at 0x102 captured right after DONE.
    snapshot;
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 3'b001);
    @(negedge clk);
    checkOutput("lhu_idle_stall", {31'b0, stall}, 32'd1);
    tick;
    busAck = 1'b1;
    @(negedge clk);
    checkOutput("lhu_addr", busAddr, 32'h100);
    checkOutput("lhu_be", {28'b0, busBe}, 32'hC);
    tick;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("lhu_result", result, 32'h000080FF);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    checkOutput("lhu_done_cycles", doneCycles - startDone, 32'd1);

    // Store byte at 0x201.
    tick;
    applyStimulus(1'b1, 1'b1, 32'h201, 32'h123456AB, 2'b01, 3'b000);
    tick;
    busAck = 1'b1;
    busRdata = 32'h55555555;
    @(negedge clk);
    checkOutput("sb_we", {31'b0, busWe}, 32'd1);
    checkOutput("sb_addr", busAddr, 32'h200);
    checkOutput("sb_be", {28'b0, busBe}, 32'h2);
    checkOutput("sb_wdata", busWdata, 32'hABABABAB);
    tick;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("sb_done", {31'b0, done}, 32'd1);
    checkOutput("sb_result", result, 32'd0);
    tick;

    // Store with size code 11 behaves as a word store.
    applyStimulus(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 2'b11, 3'b111);
    tick;
    busAck = 1'b1;
    @(negedge clk);
    checkOutput("sw11_be", {28'b0, busBe}, 32'hF);
    checkOutput("sw11_wdata", busWdata, 32'hCAFEF00D);
    tick;
    busAck = 1'b0;
    tick;

    // Misaligned word load at 0x006.
    snapshot;
    applyStimulus(1'b1, 1'b0, 32'h006, 32'h0, 2'b00, 3'b100);
    @(negedge clk);
    checkOutput("mis_idle_stall", {31'b0, stall}, 32'd1);
    checkOutput("mis_idle_done", {31'b0, done}, 32'd0);
    tick;
    @(negedge clk);
    checkOutput("mis_done", {31'b0, done}, 32'd1);
    checkOutput("mis_flag", {31'b0, misalign}, 32'd1);
    checkOutput("mis_result", result, 32'd0);
    checkOutput("mis_stall", {31'b0, stall}, 32'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    checkOutput("mis_req_cycles", reqCycles - startReq, 32'd0);
    checkOutput("mis_stall_cycles", stallCycles - startStall, 32'd1);
    @(negedge clk);
    checkOutput("mis_pulse_end", {31'b0, misalign}, 32'd0);
    tick;

    // Word load with acknowledge in the third REQ cycle.
    snapshot;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 3'b100);
    for (int i = 1; i <= 3; i++) begin
      tick;
      if (i == 3) begin
        busAck = 1'b1;
        busRdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      checkOutput($sformatf("dly_addr_%0d", i), busAddr, 32'h40);
      checkOutput($sformatf("dly_be_%0d", i), {28'b0, busBe}, 32'hF);
    end
    tick;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("dly_result", result, 32'hDEADBEEF);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    checkOutput("dly_req_cycles", reqCycles - startReq, 32'd3);
    checkOutput("dly_stall_cycles", stallCycles - startStall, 32'd4);
    checkOutput("dly_done_cycles", doneCycles - startDone, 32'd1);

    // Spurious acknowledge while idle.
    snapshot;
    busAck = 1'b1;
    busRdata = 32'h12345678;
    tick;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("spur_req", {31'b0, busReq}, 32'd0);
    checkOutput("spur_done", {31'b0, done}, 32'd0);
    tick;
    checkOutput("spur_done_cycles", doneCycles - startDone, 32'd0);

    // Reset asserted during REQ, acknowledge one cycle later.
    applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 2'b00, 3'b100);
    tick;
    @(negedge clk);
    checkOutput("rmid_req_before", {31'b0, busReq}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("rmid_req_drop", {31'b0, busReq}, 32'd0);
    checkOutput("rmid_done", {31'b0, done}, 32'd0);
    checkOutput("rmid_be", {28'b0, busBe}, 32'd0);
    snapshot;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
    tick;
    resetN = 1'b1;
    busAck = 1'b1;
    busRdata = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("rmid_ack_req", {31'b0, busReq}, 32'd0);
    checkOutput("rmid_ack_done", {31'b0, done}, 32'd0);
    tick;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("rmid_result", result, 32'd0);
    checkOutput("rmid_after_done", {31'b0, done}, 32'd0);
    tick;
    checkOutput("rmid_done_cycles", doneCycles - startDone, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
